captura_jogada: RTL and testbench



---
 rtl/captura_jogada_if.sv | 21 ++
 rtl/captura_jogada.sv | 135 +++++++++++++
 tb/tb_captura_jogada.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/captura_jogada_if.sv
// Move-capture bus: arming/clear controls and buttons in, captured move and status pulses out.
interface captura_jogada_if;
   logic       inicia;
   logic       limpa;
   logic [3:0] botoes;
   logic [3:0] jogada;
   logic       jogada_feita;
   logic       jogada_invalida;
   logic       aguardando;
   logic       timeout;

   modport master (
      output inicia, limpa, botoes,
      input  jogada, jogada_feita, jogada_invalida, aguardando, timeout
   );

   modport slave (
      input  inicia, limpa, botoes,
      output jogada, jogada_feita, jogada_invalida, aguardando, timeout
   );
endinterface

// File: rtl/captura_jogada.sv
// Captures one debounced one-hot move from four raw buttons per arming,
// with invalid-press rejection and a wait timeout.
module captura_jogada #(
   parameter int DEBOUNCE = 4,
   parameter int TIMEOUT  = 5000
) (
   input  logic              clock,
   input  logic              reset_n,
   captura_jogada_if.slave   bus
);

   localparam int DBW = $clog2(DEBOUNCE + 1);
   localparam int TOW = $clog2(TIMEOUT);
   localparam logic [DBW-1:0] DB_ONE  = DBW'(1);
   localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE);
   localparam logic [TOW-1:0] TO_ONE  = TOW'(1);
   localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      OCIOSO, ESPERA, ESTABILIZA, REGISTRA, SOLTURA, EXPIROU
   } estado_t;

   estado_t        estado_q, estado_d;
   logic [3:0]     sinc_q;
   logic [3:0]     botoes_s_q;
   logic [DBW-1:0] cnt_db_q, cnt_db_d;
   logic [TOW-1:0] cnt_to_q, cnt_to_d;
   logic [3:0]     amostra_q, amostra_d;
   logic [3:0]     jogada_q, jogada_d;
   logic           feita_q, feita_d;
   logic           invalida_q, invalida_d;
   logic           aguardando_q, aguardando_d;
   logic           timeout_q, timeout_d;

   always_comb begin
      estado_d  = estado_q;
      cnt_db_d  = cnt_db_q;
      cnt_to_d  = cnt_to_q;
      amostra_d = amostra_q;
      jogada_d  = jogada_q;

      case (estado_q)
         OCIOSO: begin
            if (bus.inicia) estado_d = ESPERA;
         end
         ESPERA: begin
            // A press seen on the expiry cycle still wins over the timeout.
            if (botoes_s_q != 4'b0000) begin
               estado_d  = ESTABILIZA;
               amostra_d = botoes_s_q;
            end else if (cnt_to_q == TO_LAST) begin
               estado_d = EXPIROU;
            end else begin
               cnt_to_d = cnt_to_q + TO_ONE;
            end
         end
         ESTABILIZA: begin
            if (botoes_s_q == 4'b0000) begin
               estado_d = ESPERA;
            end else if (botoes_s_q == amostra_q) begin
               if (cnt_db_q + DB_ONE == DB_MAX) estado_d = REGISTRA;
               else if (cnt_db_q != DB_MAX)     cnt_db_d = cnt_db_q + DB_ONE;
            end else begin
               amostra_d = botoes_s_q;
               cnt_db_d  = DB_ONE;
            end
         end
         REGISTRA: begin
            estado_d = SOLTURA;
         end
         SOLTURA: begin
            if (botoes_s_q != 4'b0000)            cnt_db_d = '0;
            else if (cnt_db_q + DB_ONE == DB_MAX) estado_d = OCIOSO;
            else                                  cnt_db_d = cnt_db_q + DB_ONE;
         end
         EXPIROU: begin
            estado_d = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase

      if (bus.limpa) estado_d = OCIOSO;

      // Counters restart on every state change; a fresh press starts at one stable sample.
      if (estado_d != estado_q) begin
         cnt_db_d = (estado_d == ESTABILIZA) ? DB_ONE : '0;
         cnt_to_d = '0;
      end

      feita_d      = (estado_d == REGISTRA) &&  $onehot(amostra_d);
      invalida_d   = (estado_d == REGISTRA) && !$onehot(amostra_d);
      timeout_d    = (estado_d == EXPIROU);
      aguardando_d = (estado_d == ESPERA) || (estado_d == ESTABILIZA);

      if (feita_d)   jogada_d = amostra_d;
      if (bus.limpa) jogada_d = 4'b0000;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q     <= OCIOSO;
         sinc_q       <= '0;
         botoes_s_q   <= '0;
         cnt_db_q     <= '0;
         cnt_to_q     <= '0;
         amostra_q    <= '0;
         jogada_q     <= '0;
         feita_q      <= 1'b0;
         invalida_q   <= 1'b0;
         aguardando_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         sinc_q       <= bus.botoes;
         botoes_s_q   <= sinc_q;
         cnt_db_q     <= cnt_db_d;
         cnt_to_q     <= cnt_to_d;
         amostra_q    <= amostra_d;
         jogada_q     <= jogada_d;
         feita_q      <= feita_d;
         invalida_q   <= invalida_d;
         aguardando_q <= aguardando_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.jogada          = jogada_q;
   assign bus.jogada_feita    = feita_q;
   assign bus.jogada_invalida = invalida_q;
   assign bus.aguardando      = aguardando_q;
   assign bus.timeout         = timeout_q;

endmodule

// File: tb/tb_captura_jogada.sv
// Directed bench for captura_jogada: an event-level model checked every cycle,
// plus hand-computed latency and value expectations.
module tb_captura_jogada;

   localparam int DEBOUNCE = 4;
   localparam int TIMEOUT  = 10;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   cyc     = 0;

   captura_jogada_if bus();

   captura_jogada #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model: tracks the synchronised button history as runs of equal samples.
   logic [3:0] s1, s2, m_jog, run_val;
   bit         armed, releasing, m_feita, m_inval, m_to;
   int         run_len, zero_run, idle_cnt;

   task automatic model_reset();
      s1 = '0; s2 = '0; m_jog = '0; run_val = '0;
      armed = 0; releasing = 0; m_feita = 0; m_inval = 0; m_to = 0;
      run_len = 0; zero_run = 0; idle_cnt = 0;
   endtask

   task automatic model_step();
      bit reported, expired;
      reported = m_feita | m_inval;
      expired  = m_to;
      m_feita = 0; m_inval = 0; m_to = 0;
      if (bus.limpa) begin
         armed = 0; releasing = 0; m_jog = '0;
      end else if (reported) begin
         releasing = 1; zero_run = 0;
      end else if (expired) begin
         armed = 0;
      end else if (releasing) begin
         if (s2 == 4'b0000) begin
            zero_run++;
            if (zero_run == DEBOUNCE) releasing = 0;
         end else begin
            zero_run = 0;
         end
      end else if (armed) begin
         if (s2 != 4'b0000) begin
            if (run_len > 0 && s2 == run_val) begin
               run_len++;
               if (run_len == DEBOUNCE) begin
                  armed = 0;
                  if ($countones(run_val) == 1) begin
                     m_jog = run_val; m_feita = 1;
                  end else begin
                     m_inval = 1;
                  end
               end
            end else begin
               run_val = s2; run_len = 1;
            end
         end else if (run_len > 0) begin
            run_len = 0; idle_cnt = 0;
         end else if (idle_cnt == TIMEOUT - 1) begin
            armed = 0; m_to = 1;
         end else begin
            idle_cnt++;
         end
      end else if (bus.inicia) begin
         armed = 1; idle_cnt = 0; run_len = 0;
      end
      s2 = s1;
      s1 = bus.botoes;
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) model_reset();
      else          model_step();
   end

   int feita_cnt = 0, inval_cnt = 0, to_cnt = 0;
   int feita_cyc = -1, to_cyc = -1;

   always @(negedge clock) begin
      chk("jogada",          32'(bus.jogada),          32'(m_jog));
      chk("jogada_feita",    32'(bus.jogada_feita),    32'(m_feita));
      chk("jogada_invalida", 32'(bus.jogada_invalida), 32'(m_inval));
      chk("aguardando",      32'(bus.aguardando),      32'(armed));
      chk("timeout",         32'(bus.timeout),         32'(m_to));
      if (bus.jogada_feita)    begin feita_cnt <= feita_cnt + 1; feita_cyc <= cyc; end
      if (bus.jogada_invalida) inval_cnt <= inval_cnt + 1;
      if (bus.timeout)         begin to_cnt <= to_cnt + 1; to_cyc <= cyc; end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic arm();
      bus.inicia = 1'b1;
      tick(1);
      bus.inicia = 1'b0;
   endtask

   initial begin
      int e0, r0, s, n, f0, i0, t0;
      bus.inicia = 1'b0;
      bus.limpa  = 1'b0;
      bus.botoes = 4'b0000;

      tick(3);
      chk("reset_jogada", 32'(bus.jogada), 32'h0);
      chk("reset_aguardando", 32'(bus.aguardando), 32'h0);
      reset_n = 1'b1;
      tick(2);

      // Clean press of 0100
      f0 = feita_cnt;
      arm();
      bus.botoes = 4'b0100;
      e0 = cyc + 1;
      tick(20);
      chk("clean_pulses", 32'(feita_cnt - f0), 32'd1);
      chk("clean_latency", 32'(feita_cyc), 32'(e0 + 5));
      chk("clean_jogada", 32'(bus.jogada), 32'h4);
      $display("clean press: jogada=%b feita at cycle %0d", bus.jogada, feita_cyc);

      // Release with inicia held: ESPERA follows the first OCIOSO cycle
      bus.botoes = 4'b0000;
      bus.inicia = 1'b1;
      r0 = cyc + 1;
      n = 0;
      while (bus.aguardando !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      bus.inicia = 1'b0;
      chk("release_to_idle", 32'(cyc), 32'(r0 + 6));
      $display("release: rearmed at cycle %0d", cyc);

      // Bounce then stable 0010
      f0 = feita_cnt;
      for (int i = 0; i < 6; i++) begin
         bus.botoes = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         tick(1);
      end
      bus.botoes = 4'b0010;
      e0 = cyc + 1;
      tick(12);
      chk("bounce_pulses", 32'(feita_cnt - f0), 32'd1);
      chk("bounce_latency", 32'(feita_cyc), 32'(e0 + 5));
      chk("bounce_jogada", 32'(bus.jogada), 32'h2);
      $display("bounce: jogada=%b feita at cycle %0d", bus.jogada, feita_cyc);
      bus.botoes = 4'b0000;
      tick(10);

      // Capture 0001, then press 1000 without arming
      arm();
      bus.botoes = 4'b0001;
      tick(10);
      bus.botoes = 4'b0000;
      tick(10);
      chk("capture_0001", 32'(bus.jogada), 32'h1);
      f0 = feita_cnt;
      bus.botoes = 4'b1000;
      tick(10);
      bus.botoes = 4'b0000;
      tick(10);
      chk("unarmed_pulses", 32'(feita_cnt - f0), 32'd0);
      chk("unarmed_jogada", 32'(bus.jogada), 32'h1);
      $display("unarmed press: jogada=%b", bus.jogada);

      // Invalid two-button press
      f0 = feita_cnt;
      i0 = inval_cnt;
      arm();
      bus.botoes = 4'b0011;
      tick(10);
      bus.botoes = 4'b0000;
      tick(10);
      chk("invalid_pulses", 32'(inval_cnt - i0), 32'd1);
      chk("invalid_no_feita", 32'(feita_cnt - f0), 32'd0);
      chk("invalid_jogada", 32'(bus.jogada), 32'h1);
      $display("invalid press: jogada=%b invalid pulses=%0d", bus.jogada, inval_cnt - i0);

      // Timeout with no press, then a press that must be ignored
      t0 = to_cnt;
      arm();
      s = cyc;
      tick(14);
      chk("timeout_pulses", 32'(to_cnt - t0), 32'd1);
      chk("timeout_latency", 32'(to_cyc), 32'(s + 10));
      chk("timeout_aguardando", 32'(bus.aguardando), 32'h0);
      f0 = feita_cnt;
      i0 = inval_cnt;
      bus.botoes = 4'b0100;
      tick(10);
      bus.botoes = 4'b0000;
      tick(10);
      chk("post_timeout_feita", 32'(feita_cnt - f0), 32'd0);
      chk("post_timeout_invalid", 32'(inval_cnt - i0), 32'd0);
      $display("timeout: pulse at cycle %0d", to_cyc);

      // limpa while stabilising
      f0 = feita_cnt;
      arm();
      bus.botoes = 4'b1000;
      tick(3);
      chk("limpa_pre_aguardando", 32'(bus.aguardando), 32'h1);
      bus.limpa = 1'b1;
      tick(1);
      bus.limpa = 1'b0;
      chk("limpa_jogada", 32'(bus.jogada), 32'h0);
      chk("limpa_aguardando", 32'(bus.aguardando), 32'h0);
      tick(6);
      bus.botoes = 4'b0000;
      tick(8);
      chk("limpa_no_feita", 32'(feita_cnt - f0), 32'd0);
      $display("limpa: jogada=%b", bus.jogada);

      // Asynchronous reset during release
      arm();
      bus.botoes = 4'b0100;
      tick(9);
      chk("pre_reset_jogada", 32'(bus.jogada), 32'h4);
      reset_n = 1'b0;
      #1;
      chk("async_reset_jogada", 32'(bus.jogada), 32'h0);
      chk("async_reset_feita", 32'(bus.jogada_feita), 32'h0);
      chk("async_reset_invalid", 32'(bus.jogada_invalida), 32'h0);
      chk("async_reset_aguardando", 32'(bus.aguardando), 32'h0);
      chk("async_reset_timeout", 32'(bus.timeout), 32'h0);
      $display("async reset: jogada=%b", bus.jogada);
      bus.botoes = 4'b0000;
      tick(2);
      reset_n = 1'b1;
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
